p_bit_field_accumulator: RTL and testbench
==========================================

Name: p_bit_field_accumulator

Overview:
- Produces the signed local field that drives a p_bit's input_val, computed as I = h + sum over j of J_j * m_j.
- Each m_j is the bipolar value of neighbour p_bit output j: output 1 means +1, output 0 means -1.
- Sits between the p_bit outputs and a p_bit input, closing the network loop.
- Weights and bias are loaded through a register write port. The sum is computed serially, one neighbour per cycle, and the result is saturated to the p_bit input width.

Parameters:
- N, 4: number of neighbour spins and weights.
- W_WIDTH, 4: signed width of each weight and of the bias.
- ACC_WIDTH, 8: signed accumulator width. Must hold N*2^(W_WIDTH-1) + 2^(W_WIDTH-1) plus a sign bit.
- OUT_WIDTH, 4: signed width of input_val, matching the p_bit input.
- AW, 2: weight address width, equal to clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  weight/bias write strobe.
- waddr  input  AW+1  write address. MSB=0 selects weight[waddr[AW-1:0]]; MSB=1 selects bias.
- wdata  input  W_WIDTH  signed write data.
- start  input  1  single-cycle request to compute the field.
- spins  input  N  neighbour p_bit outputs; bit j is m_j.
- busy  output  1  high while a computation is in flight.
- valid  output  1  one-cycle pulse when input_val updates.
- input_val  output  OUT_WIDTH  signed, saturated field; held between updates.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy=0, valid=0, input_val=0.
  - All weights, bias, accumulator and index clear to 0.
  - Reset takes effect immediately, including mid-computation. The partial result is discarded and input_val does not update.
- State machine: IDLE -> ACCUM -> DONE -> IDLE.
  - IDLE: on start=1, latch spins into spin_q, load acc = sign-extended bias, set idx=0, go to ACCUM. busy rises in the next cycle.
  - ACCUM: each cycle, acc += m_idx ? +weight[idx] : -weight[idx], with the weight sign-extended to ACC_WIDTH. -(-2^(W_WIDTH-1)) must yield the positive value with no wrap. idx increments; after idx=N-1, go to DONE. ACCUM lasts exactly N cycles.
  - DONE: input_val = sat(acc), which is 2^(OUT_WIDTH-1)-1 if acc exceeds it, -2^(OUT_WIDTH-1) if acc is below it, otherwise acc truncated. valid=1 for this one cycle. Go to IDLE. busy=0 in DONE.
- Latency: start sampled at edge t gives valid=1 and the new input_val registered at edge t+N+1. A new start may be accepted in the cycle after valid.
- Handshake rules:
  - start while busy=1 or in DONE is ignored; it is not queued.
  - Changes on spins after the start cycle do not affect the result.
- Writes:
  - Accepted only in IDLE with start=0; take effect at the next edge.
  - We while busy, in DONE, or coincident with start are ignored, so the weight set stays consistent.
  - Writes to waddr MSB=0 with index >= N are ignored.
- input_val holds its last value between computations. valid is never high for two consecutive cycles.

Test Plan:
1. Load all weights=+1, bias=0, spins=4'b1111, pulse start at edge t -> busy high for 4 cycles; valid pulses at t+5; input_val=4.
2. Load weight[0..3]=3,-2,5,1, bias=-4, spins=4'b0101 -> acc = -4+3+2+5-1 = 5; input_val=5.
3. Saturation: weights all 7, bias=7, spins=4'b1111 -> acc=35, input_val=7. Then bias=-8, weights all -8, spins=4'b1111 -> acc=-40, input_val=-8. Then weights all -8, spins=4'b0000, bias=7 -> acc=+39 (checks negation of -8), input_val=7.
4. Protocol: pulse start again 2 cycles into ACCUM, and assert we to weight[0] during ACCUM -> exactly one valid pulse; result matches pre-write weights; a following idle read shows weight[0] unchanged.
5. Reset mid-op: previous input_val=5; assert reset=0 asynchronously mid-ACCUM (between edges) -> busy=0, valid=0, input_val=0 immediately; no valid after release. A subsequent start with all weights=0, bias=0 -> input_val=0.
6. Spin hold: start with spins=4'b1111 and weights all +1, then flip spins to 4'b0000 the next cycle -> input_val=4.

Source files
------------

// File: rtl/p_bit_field_accumulator.sv
// Serial local-field accumulator for a p-bit: I = h + sum_j J_j * m_j, with m_j = +1/-1 from
// neighbour outputs, saturated to the p-bit input width. Weights and bias load via a write port.
module p_bit_field_accumulator #(
    parameter int unsigned N         = 4,
    parameter int unsigned W_WIDTH   = 4,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned AW        = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        we_i,
    input  logic [AW:0]                 waddr_i,
    input  logic signed [W_WIDTH-1:0]   wdata_i,
    input  logic                        start_i,
    input  logic [N-1:0]                spins_i,
    output logic                        busy_o,
    output logic                        valid_o,
    output logic signed [OUT_WIDTH-1:0] input_val_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic signed [ACC_WIDTH-1:0] AccMax = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] AccMin = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    state_e                        state_q;
    logic signed [W_WIDTH-1:0]     weight_q [N];
    logic signed [W_WIDTH-1:0]     bias_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [AW-1:0]                 idx_q;
    logic [N-1:0]                  spin_q;
    logic                          busy_q;
    logic                          valid_q;
    logic signed [OUT_WIDTH-1:0]   input_val_q;

    logic                          wr_en;
    logic signed [ACC_WIDTH-1:0]   w_ext;
    logic signed [ACC_WIDTH-1:0]   term;
    logic signed [OUT_WIDTH-1:0]   sat_val;

    // Writes only land while idle and not starting, so a computation always sees one weight set.
    assign wr_en = we_i && (state_q == StIdle) && !start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                weight_q[i] <= '0;
            end
            bias_q <= '0;
        end else if (wr_en) begin
            if (waddr_i[AW]) begin
                bias_q <= wdata_i;
            end else if ({1'b0, waddr_i[AW-1:0]} < (AW + 1)'(N)) begin
                weight_q[waddr_i[AW-1:0]] <= wdata_i;
            end
        end
    end

    always_comb begin
        w_ext = ACC_WIDTH'(weight_q[idx_q]);
        // Negation happens after sign extension so the most negative weight cannot wrap.
        term  = spin_q[idx_q] ? w_ext : -w_ext;
        if (acc_q > AccMax) begin
            sat_val = AccMax[OUT_WIDTH-1:0];
        end else if (acc_q < AccMin) begin
            sat_val = AccMin[OUT_WIDTH-1:0];
        end else begin
            sat_val = acc_q[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            idx_q       <= '0;
            spin_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            input_val_q <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        spin_q  <= spins_i;
                        acc_q   <= ACC_WIDTH'(bias_q);
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    acc_q <= acc_q + term;
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == AW'(N - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    input_val_q <= sat_val;
                    valid_q     <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign input_val_o = input_val_q;

endmodule

// File: tb/tb_p_bit_field_accumulator.sv
// Bench for p_bit_field_accumulator: directed scenarios plus randomized weights/spins checked
// against an integer model of the saturated field h + sum(J_j * m_j).
module tb_p_bit_field_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic [2:0]        waddr;
    logic [3:0]        wdata;
    logic              start;
    logic [3:0]        spins;
    logic              busy;
    logic              valid;
    logic signed [3:0] input_val;

    int total_cnt = 0;
    int pass_cnt  = 0;

    int mw[4];
    int mb;

    p_bit_field_accumulator dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .start_i    (start),
        .spins_i    (spins),
        .busy_o     (busy),
        .valid_o    (valid),
        .input_val_o(input_val)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [3:0] sp);
        int s;
        s = mb;
        for (int j = 0; j < 4; j++) s += sp[j] ? mw[j] : -mw[j];
        if (s > 7) s = 7;
        if (s < -8) s = -8;
        return 4'(s);
    endfunction

    task automatic write_reg(input logic [2:0] a, input int v);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = 4'(v);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic load_all(input int w0, input int w1, input int w2, input int w3, input int b);
        mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3; mb = b;
        for (int j = 0; j < 4; j++) write_reg(3'(j), mw[j]);
        write_reg(3'b100, b);
    endtask

    // Pulses start with sp, switches spins to sp_after one cycle later, observes 12 cycles.
    task automatic run_op(input logic [3:0] sp, input logic [3:0] sp_after, input bit junk_we,
                          output logic [3:0] val, output int busy_cnt, output int valid_idx,
                          output int valid_cnt);
        @(negedge clk);
        start = 1'b1; spins = sp;
        if (junk_we) begin
            we = 1'b1; waddr = 3'($urandom_range(7)); wdata = 4'($urandom_range(15));
        end
        @(negedge clk);
        start = 1'b0; we = 1'b0;
        busy_cnt = 0; valid_cnt = 0; valid_idx = -1; val = 'x;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (valid) begin
                valid_cnt++;
                if (valid_idx < 0) valid_idx = k;
                val = input_val;
            end
            if (k == 1) spins = sp_after;
        end
    endtask

    task automatic check_op(input string name, input logic [3:0] got, input logic [3:0] exp,
                            input int bc, input int vi, input int vc);
        total_cnt++;
        if (got !== exp) $display("FAIL %s value: got %0d want %0d", name, $signed(got),
                                  $signed(exp));
        else pass_cnt++;
        total_cnt++;
        if (bc !== 4 || vi !== 6 || vc !== 1)
            $display("FAIL %s timing: busy=%0d valid_at=%0d valids=%0d want 4/6/1", name, bc, vi,
                     vc);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        logic [3:0] v; int bc, vi, vc;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; start = 1'b0; spins = '0;
        #12;
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0 || input_val !== 4'sd0)
            $display("FAIL reset outputs: busy=%b valid=%b val=%0d want 0/0/0", busy, valid,
                     input_val);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        mw = '{0, 0, 0, 0}; mb = 0;
        run_op(4'b1010, 4'b1010, 1'b0, v, bc, vi, vc);
        check_op("reset_cleared_weights", v, model(4'b1010), bc, vi, vc);
    endtask

    task automatic test_basic;
        logic [3:0] v; int bc, vi, vc;
        load_all(1, 1, 1, 1, 0);
        run_op(4'b1111, 4'b1111, 1'b0, v, bc, vi, vc);
        check_op("all_plus_one", v, 4'sd4, bc, vi, vc);
        load_all(3, -2, 5, 1, -4);
        run_op(4'b0101, 4'b0101, 1'b0, v, bc, vi, vc);
        check_op("mixed_weights", v, 4'sd5, bc, vi, vc);
    endtask

    task automatic test_saturation;
        logic [3:0] v; int bc, vi, vc;
        load_all(7, 7, 7, 7, 7);
        run_op(4'b1111, 4'b1111, 1'b0, v, bc, vi, vc);
        check_op("sat_pos", v, 4'sd7, bc, vi, vc);
        load_all(-8, -8, -8, -8, -8);
        run_op(4'b1111, 4'b1111, 1'b0, v, bc, vi, vc);
        check_op("sat_neg", v, 4'b1000, bc, vi, vc);
        write_reg(3'b100, 7); mb = 7;
        run_op(4'b0000, 4'b0000, 1'b0, v, bc, vi, vc);
        check_op("negate_min_weight", v, 4'sd7, bc, vi, vc);
    endtask

    task automatic test_protocol;
        logic [3:0] v; int bc, vi, vc;
        load_all(3, -2, 5, 1, -4);
        @(negedge clk); start = 1'b1; spins = 4'b0101;
        @(negedge clk); start = 1'b0;
        vc = 0; v = 'x;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (valid) begin vc++; v = input_val; end
            if (k == 2) begin start = 1'b1; we = 1'b1; waddr = 3'b000; wdata = 4'b1001; end
            if (k == 3) begin start = 1'b0; we = 1'b0; end
        end
        total_cnt++;
        if (vc !== 1 || v !== model(4'b0101))
            $display("FAIL protocol_ignore: valids=%0d val=%0d want 1/%0d", vc, $signed(v),
                     $signed(model(4'b0101)));
        else pass_cnt++;
        run_op(4'b0101, 4'b0101, 1'b0, v, bc, vi, vc);
        check_op("weight0_unchanged", v, 4'sd5, bc, vi, vc);
    endtask

    task automatic test_reset_mid;
        logic [3:0] v; int bc, vi, vc;
        @(negedge clk); start = 1'b1; spins = 4'b1111;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0 || input_val !== 4'sd0)
            $display("FAIL reset_mid outputs: busy=%b valid=%b val=%0d want 0/0/0", busy, valid,
                     input_val);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        vc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid) vc++;
        end
        total_cnt++;
        if (vc !== 0) $display("FAIL reset_mid stray valid: got %0d want 0", vc);
        else pass_cnt++;
        mw = '{0, 0, 0, 0}; mb = 0;
        run_op(4'b0110, 4'b0110, 1'b0, v, bc, vi, vc);
        check_op("after_reset_zero", v, 4'sd0, bc, vi, vc);
    endtask

    task automatic test_spin_hold;
        logic [3:0] v; int bc, vi, vc;
        load_all(1, 1, 1, 1, 0);
        run_op(4'b1111, 4'b0000, 1'b0, v, bc, vi, vc);
        check_op("spin_hold", v, 4'sd4, bc, vi, vc);
    endtask

    task automatic test_random;
        logic [3:0] v, sp; int bc, vi, vc;
        for (int it = 0; it < 25; it++) begin
            load_all(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                     int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                     int'($urandom_range(15)) - 8);
            sp = 4'($urandom_range(15));
            run_op(sp, 4'($urandom_range(15)), 1'b1, v, bc, vi, vc);
            check_op($sformatf("random_%0d", it), v, model(sp), bc, vi, vc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_protocol();
        test_reset_mid();
        test_spin_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
